// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - serialises cache load/store tasks into byte accesses on the 8-bit RAM/IO bus
// Optional: define MEM_IO_STALL_EN to stall IO-region writes while io_buffer_full is high.
module mem_byte_sequencer #(
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        rob_clear,
  input  logic        new_task,
  input  logic        is_write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [2:0]  work_type,
  output logic [31:0] data_out,
  output logic        real_ready_out,
  output logic        is_working
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [1:0]  last_q, last_d;
  logic        sign_q, sign_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic [31:0] data_out_q, data_out_d;
  logic        ready_q, ready_d;
  logic        io_stall;
  logic [1:0]  nidx;
  logic [31:0] next_addr;

`ifdef MEM_IO_STALL_EN
  assign io_stall = io_buffer_full && (mem_a_q >= IO_BASE);
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  // Little-endian bytes already packed in r; extend from the top bit of the task size.
  function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] last,
                                         input logic s);
    logic [31:0] v;
    case (last)
      2'd0:    v = {{24{s & r[7]}}, r[7:0]};
      2'd1:    v = {{16{s & r[15]}}, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  assign nidx      = cnt_q + 2'd1;
  assign next_addr = base_q + {30'd0, nidx};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    last_d     = last_q;
    sign_d     = sign_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (new_task && !rob_clear) begin
          base_d  = addr;
          sign_d  = work_type[2];
          wdata_d = data_in;
          cnt_d   = 2'd0;
          mem_a_d = addr;
          case (work_type[1:0])
            2'b00:   last_d = 2'd0;
            2'b01:   last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
          if (is_write) begin
            dout_d  = data_in[7:0];
            wr_d    = 1'b1;
            state_d = ST_WRITE;
          end else begin
            wr_d    = 1'b0;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (rob_clear) begin
          state_d = ST_IDLE;
          mem_a_d = 32'd0;
          cnt_d   = 2'd0;
        end else begin
          rbuf_d[{cnt_q, 3'b000} +: 8] = mem_din;
          if (cnt_q == last_q) begin
            data_out_d = extend(rbuf_d, last_q, sign_q);
            ready_d    = 1'b1;
            cnt_d      = 2'd0;
            state_d    = ST_IDLE;
          end else begin
            cnt_d   = nidx;
            mem_a_d = next_addr;
          end
        end
      end
      ST_WRITE: begin
        // Stores ignore rob_clear: a byte already on the bus cannot be recalled.
        if (!io_stall) begin
          if (cnt_q == last_q) begin
            ready_d = 1'b1;
            wr_d    = 1'b0;
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = nidx;
            mem_a_d = next_addr;
            dout_d  = wdata_q[{nidx, 3'b000} +: 8];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      base_q     <= 32'd0;
      last_q     <= 2'd0;
      sign_q     <= 1'b0;
      wdata_q    <= 32'd0;
      cnt_q      <= 2'd0;
      rbuf_q     <= 32'd0;
      mem_a_q    <= 32'd0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      data_out_q <= 32'd0;
      ready_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      base_q     <= base_d;
      last_q     <= last_d;
      sign_q     <= sign_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
    end
  end

  assign mem_a          = mem_a_q;
  assign mem_dout       = dout_q;
  assign mem_wr         = wr_q && rdy_in && !io_stall;
  assign data_out       = data_out_q;
  assign real_ready_out = ready_q;
  assign is_working     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - scoreboard bench for mem_byte_sequencer
module tb_mem_byte_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        rob_clear;
  logic        new_task;
  logic        is_write;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [2:0]  work_type;
  logic [31:0] data_out;
  logic        real_ready_out;
  logic        is_working;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        is_pulse;
    logic        chk;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [7:0] ram [0:262143];

  mem_byte_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .rob_clear(rob_clear), .new_task(new_task),
    .is_write(is_write), .addr(addr), .data_in(data_in), .work_type(work_type),
    .data_out(data_out), .real_ready_out(real_ready_out), .is_working(is_working)
  );

  always #5 clk_in = ~clk_in;

  assign mem_din = ram[mem_a[17:0]];

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h80;
    ram[18'h200] = 8'h78;
    ram[18'h201] = 8'h56;
    ram[18'h202] = 8'h34;
    ram[18'h203] = 8'h12;
    ram[18'h210] = 8'h00;
    ram[18'h211] = 8'h90;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] a, input logic [7:0] d);
    exp_q.push_back('{is_pulse: 1'b0, chk: 1'b1, a: a, d: {24'd0, d}});
  endtask

  task automatic push_r(input logic [31:0] d);
    exp_q.push_back('{is_pulse: 1'b1, chk: 1'b1, a: 32'd0, d: d});
  endtask

  task automatic push_p();
    exp_q.push_back('{is_pulse: 1'b1, chk: 1'b0, a: 32'd0, d: 32'd0});
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] wt);
    int g = 0;
    while (!is_working && g < 50) begin
      @(posedge clk_in); #1;
      g++;
    end
    if (!is_working) check("accept_wait", 32'd0, 32'd1);
    new_task  = 1'b1;
    is_write  = w;
    addr      = a;
    data_in   = d;
    work_type = wt;
    @(posedge clk_in); #1;
    new_task = 1'b0;
  endtask

  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk_in); #1;
      cyc++;
    end while (!real_ready_out && cyc < 40);
    if (!real_ready_out) check("pulse_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every bus write and every completion pulse consumes one expectation.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (mem_wr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", mem_a, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_kind", {31'd0, mon_e.is_pulse}, 32'd0);
          check("wr_addr", mem_a, mon_e.a);
          check("wr_data", {24'd0, mem_dout}, mon_e.d);
        end
      end
      if (real_ready_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", data_out, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", {31'd0, mon_e.is_pulse}, 32'd1);
          if (mon_e.chk) check("load_data", data_out, mon_e.d);
        end
      end
    end
  end

  initial begin
    int c;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; rob_clear = 1'b0;
    new_task = 1'b0; is_write = 1'b0; addr = 32'd0; data_in = 32'd0; work_type = 3'd0;
    #2;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_ready", {31'd0, real_ready_out}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    check("rst_is_working", {31'd0, is_working}, 32'd1);

    // signed byte load
    push_r(32'hFFFF_FF80);
    issue(1'b0, 32'h100, 32'd0, 3'b100);
    check("lb_mem_a", mem_a, 32'h100);
    check("lb_mem_wr", {31'd0, mem_wr}, 32'd0);
    wait_pulse(c);
    check("lb_latency", c, 32'd1);

    // word load, then a signed half load accepted on the pulse edge
    push_r(32'h1234_5678);
    issue(1'b0, 32'h200, 32'd0, 3'b010);
    for (int k = 0; k < 4; k++) begin
      check("lw_mem_a", mem_a, 32'h200 + k);
      @(posedge clk_in); #1;
    end
    check("lw_pulse", {31'd0, real_ready_out}, 32'd1);
    check("lw_is_working", {31'd0, is_working}, 32'd1);
    push_r(32'hFFFF_9000);
    issue(1'b0, 32'h210, 32'd0, 3'b101);
    wait_pulse(c);
    check("lh_latency", c, 32'd2);

    // unsigned half store
    push_w(32'h10, 8'h34);
    push_w(32'h11, 8'h12);
    push_p();
    issue(1'b1, 32'h10, 32'hABCD_1234, 3'b001);
    check("sh_wr0", {31'd0, mem_wr}, 32'd1);
    @(posedge clk_in); #1;
    check("sh_a1", mem_a, 32'h11);
    @(posedge clk_in); #1;
    check("sh_wr_end", {31'd0, mem_wr}, 32'd0);
    check("sh_pulse", {31'd0, real_ready_out}, 32'd1);

    // rob_clear in IDLE blocks acceptance
    @(posedge clk_in); #1;
    rob_clear = 1'b1; new_task = 1'b1; is_write = 1'b0; addr = 32'h100; work_type = 3'b000;
    @(posedge clk_in); #1;
    new_task = 1'b0; rob_clear = 1'b0;
    check("blocked_idle", {31'd0, is_working}, 32'd1);

    // rob_clear in the 2nd cycle of a word load aborts silently
    issue(1'b0, 32'h200, 32'd0, 3'b010);
    @(posedge clk_in); #1;
    rob_clear = 1'b1;
    @(posedge clk_in); #1;
    rob_clear = 1'b0;
    check("abort_is_working", {31'd0, is_working}, 32'd1);
    check("abort_mem_a", mem_a, 32'd0);
    check("abort_no_pulse", {31'd0, real_ready_out}, 32'd0);
    repeat (6) @(posedge clk_in);
    #1;

    // rob_clear during a word store is ignored
    push_w(32'h300, 8'hEF);
    push_w(32'h301, 8'hBE);
    push_w(32'h302, 8'hAD);
    push_w(32'h303, 8'hDE);
    push_p();
    issue(1'b1, 32'h300, 32'hDEAD_BEEF, 3'b010);
    rob_clear = 1'b1;
    wait_pulse(c);
    rob_clear = 1'b0;
    check("sw_clear_latency", c, 32'd4);

    // buffer full below IO_BASE never stalls
    io_buffer_full = 1'b1;
    push_w(32'h2FFFF, 8'hC3);
    push_p();
    issue(1'b1, 32'h2FFFF, 32'h0000_00C3, 3'b000);
    wait_pulse(c);
    check("ram_nostall", c, 32'd1);

    // IO byte store with buffer full for 3 cycles
    push_w(32'h30000, 8'h5A);
    push_p();
    issue(1'b1, 32'h30000, 32'h0000_005A, 3'b000);
`ifdef MEM_IO_STALL_EN
    check("io_first_wr", {31'd0, mem_wr}, 32'd0);
`else
    check("io_first_wr", {31'd0, mem_wr}, 32'd1);
`endif
    c = 0;
    while (!real_ready_out && c < 40) begin
      @(posedge clk_in); #1;
      c++;
      if (c == 3) io_buffer_full = 1'b0;
    end
    io_buffer_full = 1'b0;
`ifdef MEM_IO_STALL_EN
    check("io_latency", c, 32'd4);
`else
    check("io_latency", c, 32'd1);
`endif

    // freeze 2 cycles mid word load
    @(posedge clk_in); #1;
    push_r(32'h1234_5678);
    issue(1'b0, 32'h200, 32'd0, 3'b010);
    check("frz_a0", mem_a, 32'h200);
    @(posedge clk_in); #1;
    check("frz_a1", mem_a, 32'h201);
    rdy_in = 1'b0;
    repeat (2) begin
      @(posedge clk_in); #1;
      check("frz_hold", mem_a, 32'h201);
    end
    rdy_in = 1'b1;
    wait_pulse(c);
    check("frz_latency", c + 3, 32'd6);

    // reset mid-load
    @(posedge clk_in); #1;
    issue(1'b0, 32'h200, 32'd0, 3'b010);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    check("mid_rst_mem_a", mem_a, 32'd0);
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("mid_rst_ready", {31'd0, real_ready_out}, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("mid_rst_is_working", {31'd0, is_working}, 32'd1);
    repeat (8) @(posedge clk_in);
    #1;

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
